// File: rtl/ace_ccu_snoop_conflict_tracker.sv
// ace_ccu_snoop_conflict_tracker
//
// This module is an in-order address conflict tracker for the CCU snoop
// interconnect. It sits between the arbitrated AC request and the AC output
// fork. A snoop is released only when no outstanding snoop uses the same line
// index. Entries are freed in issue order, one for each accepted snoop
// response.
//
// Handshake semantics:
//   - gnt_valid_o is combinational from req_valid_i and registered state.
//   - req_ready_o = gnt_valid_o && gnt_ready_i. That cycle the snoop is
//     recorded.
//   - Upstream holds req_valid_i/req_addr_i stable until req_ready_o.
//   - gnt_valid_o only drops while gnt_ready_i is low if req_valid_i drops.
//
// Optional feature macro: ACE_CCU_CONFLICT_STATS_EN. It adds stall_cnt_o, a
// saturating 32-bit count of cycles with req_valid_i high and gnt_valid_o low.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   req_valid_i/req_addr_i       arbitrated snoop request and its line index
//   req_ready_o                  snoop accepted and recorded
//   gnt_valid_o/gnt_ready_i      release towards the AC fork
//   clr_i                        one snoop response accepted (frees oldest)
//   count_o                      number of valid entries
//   conflict_o                   request held back by an address match
//   err_o                        sticky: clear seen while empty
//   stall_cnt_o                  stall-cycle counter (macro only)
module ace_ccu_snoop_conflict_tracker #(
  parameter int NumEntries = 4,
  parameter int AddrWidth  = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [AddrWidth-1:0]              req_addr_i,
  output logic                              gnt_valid_o,
  input  logic                              gnt_ready_i,
  input  logic                              clr_i,
  output logic [$clog2(NumEntries+1)-1:0]   count_o,
  output logic                              conflict_o,
  output logic                              err_o
`ifdef ACE_CCU_CONFLICT_STATS_EN
  ,
  output logic [31:0]                       stall_cnt_o
`endif
);

  localparam int CntW = $clog2(NumEntries + 1);
  localparam int PtrW = (NumEntries > 1) ? $clog2(NumEntries) : 1;

  logic [NumEntries-1:0] valid_q, valid_d;
  logic [AddrWidth-1:0]  addr_q [NumEntries];
  logic [AddrWidth-1:0]  addr_d [NumEntries];
  logic [PtrW-1:0]       wptr_q, wptr_d;
  logic [PtrW-1:0]       rptr_q, rptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  err_q, err_d;

  logic match;
  logic full;
  logic alloc;
  logic clear;

  // Pointers wrap explicitly so NumEntries need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(NumEntries - 1)) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

  // match and full use registered state only. An entry that is cleared this
  // cycle still blocks, and a full tracker never grants, even alongside a
  // clear.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < NumEntries; i++) begin
      if (valid_q[i] && (addr_q[i] == req_addr_i)) begin
        match = 1'b1;
      end
    end
  end

  assign full        = (count_q == CntW'(NumEntries));
  assign gnt_valid_o = req_valid_i && !match && !full;
  assign alloc       = gnt_valid_o && gnt_ready_i;
  assign req_ready_o = alloc;
  assign conflict_o  = req_valid_i && match;
  assign clear       = clr_i && (count_q != '0);
  assign count_o     = count_q;
  assign err_o       = err_q;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    err_d   = err_q;

    // The two slots cannot coincide. Equal pointers with a clear would need
    // a full tracker, and a full tracker does not allocate.
    if (clear) begin
      valid_d[rptr_q] = 1'b0;
      rptr_d          = ptr_inc(rptr_q);
    end
    if (alloc) begin
      valid_d[wptr_q] = 1'b1;
      addr_d[wptr_q]  = req_addr_i;
      wptr_d          = ptr_inc(wptr_q);
    end

    case ({alloc, clear})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (clr_i && (count_q == '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < NumEntries; i++) begin
        addr_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < NumEntries; i++) begin
        addr_q[i] <= addr_d[i];
      end
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

`ifdef ACE_CCU_CONFLICT_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (req_valid_i && !gnt_valid_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ace_ccu_snoop_conflict_tracker.sv
// Directed bench for ace_ccu_snoop_conflict_tracker (NumEntries=4, AddrWidth=8).
// Inputs are driven 1ns after each rising edge. Combinational outputs are
// checked 4ns after the edge. A monitor pops the expected-grant queue on every
// req_ready_o it sees at the falling edge.
module tb_ace_ccu_snoop_conflict_tracker;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int CW = $clog2(N + 1);
  localparam int W  = CW + AW;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i;
  logic          gnt_valid_o;
  logic          gnt_ready_i;
  logic          clr_i;
  logic [CW-1:0] count_o;
  logic          conflict_o;
  logic          err_o;
`ifdef ACE_CCU_CONFLICT_STATS_EN
  logic [31:0]   stall_cnt_o;
`endif

  ace_ccu_snoop_conflict_tracker #(.NumEntries(N), .AddrWidth(AW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .gnt_valid_o (gnt_valid_o),
    .gnt_ready_i (gnt_ready_i),
    .clr_i       (clr_i),
    .count_o     (count_o),
    .conflict_o  (conflict_o),
    .err_o       (err_o)
`ifdef ACE_CCU_CONFLICT_STATS_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  // Clock and reset
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_err;
  int           exp_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every accepted snoop must match the oldest expected
  // grant {count before allocation, addr}.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i && req_ready_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", {24'd0, req_addr_i}, 32'hFFFF_FFFF);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("grant_addr", {24'd0, req_addr_i}, {24'd0, e[AW-1:0]});
          check("grant_count", {29'd0, count_o}, {29'd0, e[W-1:AW]});
        end
      end
    end
  end

  // One cycle: drive inputs, then check outputs against hand-computed values.
  task automatic tick(input logic v, input logic [AW-1:0] a, input logic gr, input logic clr,
                      input logic e_gnt, input logic e_conf, input int e_cnt);
    @(posedge clk_i);
    #1;
    req_valid_i = v;
    req_addr_i  = a;
    gnt_ready_i = gr;
    clr_i       = clr;
    if (e_gnt && gr) exp_q.push_back({CW'(e_cnt), a});
    #3;
    check("gnt_valid", {31'd0, gnt_valid_o}, {31'd0, e_gnt});
    check("req_ready", {31'd0, req_ready_o}, {31'd0, e_gnt && gr});
    check("conflict", {31'd0, conflict_o}, {31'd0, e_conf});
    check("count", {29'd0, count_o}, 32'(e_cnt));
    check("err", {31'd0, err_o}, {31'd0, exp_err});
`ifdef ACE_CCU_CONFLICT_STATS_EN
    check("stall_cnt", stall_cnt_o, 32'(exp_stall));
`endif
    if (v && !e_gnt) exp_stall++;
    if (clr && e_cnt == 0) exp_err = 1'b1;
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; gnt_ready_i = 1'b0; clr_i = 1'b0;
    exp_err = 1'b0; exp_stall = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #3;
    check("rst_count", {29'd0, count_o}, 32'd0);
    check("rst_gnt", {31'd0, gnt_valid_o}, 32'd0);
    check("rst_ready", {31'd0, req_ready_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);

    // Basic grant, then a conflict that is released the cycle after its clear.
    tick(1, 8'h12, 1, 0, 1, 0, 0);
    tick(1, 8'h12, 1, 0, 0, 1, 1);
    tick(1, 8'h12, 1, 0, 0, 1, 1);
    tick(1, 8'h12, 1, 1, 0, 1, 1);
    tick(1, 8'h12, 1, 0, 1, 0, 0);
    tick(0, 8'h00, 0, 1, 0, 0, 1);

    // Fill to full, blocked while full even with a same-cycle clear.
    for (int i = 0; i < 4; i++) tick(1, AW'(i + 1), 1, 0, 1, 0, i);
    tick(1, 8'h05, 1, 0, 0, 0, 4);
    tick(1, 8'h05, 1, 1, 0, 0, 4);
    tick(1, 8'h05, 1, 0, 1, 0, 3);
    for (int i = 4; i > 0; i--) tick(0, 8'h00, 0, 1, 0, 0, i);
    tick(0, 8'h00, 0, 0, 0, 0, 0);

    // No allocation without gnt_ready_i.
    tick(1, 8'h33, 0, 0, 1, 0, 0);
    tick(1, 8'h33, 1, 0, 1, 0, 0);
    tick(1, 8'h33, 1, 0, 0, 1, 1);

    // Full-rate stream: allocate and clear every cycle.
    for (int i = 0; i < 6; i++) tick(1, AW'(8'h40 + i), 1, 1, 1, 0, 1);
    tick(0, 8'h00, 0, 1, 0, 0, 1);
    tick(0, 8'h00, 0, 0, 0, 0, 0);

    // Clear while empty: sticky error, count stays 0.
    tick(0, 8'h00, 0, 1, 0, 0, 0);
    tick(0, 8'h00, 0, 1, 0, 0, 0);
    tick(0, 8'h00, 0, 0, 0, 0, 0);

    // Reset mid-operation with three entries and a stalled request.
    tick(1, 8'hA1, 1, 0, 1, 0, 0);
    tick(1, 8'hA2, 1, 0, 1, 0, 1);
    tick(1, 8'hA3, 1, 0, 1, 0, 2);
    tick(1, 8'hA1, 1, 0, 0, 1, 3);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1; req_valid_i = 1'b0; gnt_ready_i = 1'b0;
    #3;
    check("mid_rst_count", {29'd0, count_o}, 32'd0);
    check("mid_rst_err", {31'd0, err_o}, 32'd0);
    check("mid_rst_gnt", {31'd0, gnt_valid_o}, 32'd0);
    exp_err = 1'b0; exp_stall = 0;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    tick(1, 8'hA1, 1, 0, 1, 0, 0);
    tick(0, 8'h00, 0, 0, 0, 0, 1);

    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check("missed_grants", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ace_ccu_snoop_conflict_tracker.md
# ace_ccu_snoop_conflict_tracker

In-order address conflict tracker that throttles snoop issue in the CCU snoop interconnect when conflict checking is enabled. It sits on the interconnect's lookup handshake, between the arbitrated AC request and the AC output fork. A snoop is released only when no outstanding snoop targets the same line index. Entries are freed in issue order as snoop responses are accepted.

## Interface
- `NumEntries`, default 4: maximum outstanding tracked snoops, ≥1; need not be a power of two.
- `AddrWidth`, default 8: width of the compared line-index slice.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  1  arbitrated snoop wants to issue (lookup valid from interconnect).
- `req_ready_o`  out  1  snoop accepted and recorded.
- `req_addr_i`  in  AddrWidth  line index of the requesting snoop.
- `gnt_valid_o`  out  1  snoop may proceed to the AC fork.
- `gnt_ready_i`  in  1  AC fork accepted the snoop.
- `clr_i`  in  1  one snoop response accepted; frees the oldest entry.
- `count_o`  out  $clog2(NumEntries+1)  number of valid entries.
- `conflict_o`  out  1  `req_valid_i` held back by an address match.
- `err_o`  out  1  sticky; set by a clear while the tracker is empty.
- `stall_cnt_o`  out  32  stall-cycle counter; present only with the macro below.

## Operation
- Storage is a circular buffer of {valid, addr} with write pointer `wptr`, read pointer `rptr` and occupancy `count`.
- `match` = OR over entries of (valid && addr == `req_addr_i`).
- `full` = (`count` == NumEntries).
- `gnt_valid_o` = `req_valid_i` && !`match` && !`full`. This path is combinational.
- `req_ready_o` = `gnt_valid_o` && `gnt_ready_i`.
- `conflict_o` = `req_valid_i` && `match`.
- **Allocate** when `req_ready_o` is high: write `req_addr_i` at `wptr` and set valid. `wptr` wraps from NumEntries-1 to 0.
- **Clear** when `clr_i` is high and `count` > 0: reset valid at `rptr`, then advance `rptr` with the same wrap.
- Clear while empty: no state change; `err_o` goes high and stays high until reset.
- Allocate and clear in the same cycle: `count` is unchanged and both pointers advance.
- `match` and `full` use registered state only. An entry being cleared in the current cycle still blocks a matching request. A full tracker does not grant even if a clear occurs that cycle.
- Duplicate addresses cannot coexist in the buffer, because a matching request is never granted.
- `count` saturates by construction. Allocation when full is impossible.
- Reset mid-operation invalidates all entries and zeroes pointers. Responses in flight across reset are the integrator's responsibility and are not tracked.

## Timing
- Reset values:
  - `req_ready_o` = 0, `gnt_valid_o` = 0 (with `req_valid_i` low)
  - `count_o` = 0, `conflict_o` = 0, `err_o` = 0, `stall_cnt_o` = 0
  - all entries invalid, `wptr` = `rptr` = 0
- Grant latency is 0 cycles from `req_valid_i` when there is no conflict and the tracker is not full.
- Stall release: the first cycle after the clearing edge of the blocking entry (earliest case: clear in cycle N, grant in cycle N+1).
- `count_o` updates one cycle after an allocate or clear.
- Handshake rules:
  - `gnt_valid_o` may drop while `gnt_ready_i` is low only if `req_valid_i` drops. Upstream must hold `req_valid_i` and `req_addr_i` stable until `req_ready_o`.
  - A newly allocated entry does not affect `match` until the next cycle.

## Configuration
- Macro: `ACE_CCU_CONFLICT_STATS_EN`.
- **Defined:**
  - `stall_cnt_o` exists.
  - It increments each cycle in which `req_valid_i` is high and `gnt_valid_o` is low (conflict or full).
  - It saturates at 2^32-1 and resets to 0.
- **Undefined:**
  - The port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Reset then idle -> all outputs 0. Request addr 0x12 with `gnt_ready_i`=1 -> `gnt_valid_o`=`req_ready_o`=1 in the same cycle; `count_o`=1 next cycle.
- Issue 0x12, then request 0x12 again -> `conflict_o`=1, `gnt_valid_o`=0. Pulse `clr_i` in cycle N -> grant in cycle N+1; `stall_cnt_o`=3 after three stalled cycles (macro defined).
- NumEntries=4: issue 0x01..0x04 -> `count_o`=4; 0x05 blocked. Clear and request in the same cycle -> still blocked; grant next cycle. After 5 allocations and 5 clears, pointers wrap correctly and `count_o`=0.
- Full-rate stream: distinct addresses with simultaneous allocate and clear every cycle -> `count_o` constant and no stalls.
- `clr_i` while empty -> `err_o`=1 and remains 1; `count_o` stays 0.
- Assert `rst_i` with 3 entries valid, including a stalled request -> after reset the same address is granted immediately and `count_o`=0.
